clk_div_ctrl: RTL



---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_ctrl_half_period_counter.sv | 30 +++
 rtl/clk_div_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock controller.
// Holds the FSM state enum and the reset-time configuration constants.
package clk_div_pkg;

  localparam int          CNT_W_D    = 28;
  localparam int          BURST_W_D  = 8;
  localparam int unsigned DEF_HALF_D = 32'd12500000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_half_period_counter.sv
// Phase-length counter: counts 0..i_term-1 while enabled, wraps itself.
// Ports: clk, reset, i_clr (restart at 0), i_en, i_term, o_phase_end.
module half_period_counter #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_phase_end
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last      = (r_cnt == i_term - CNT_W'(1));
  assign o_phase_end = i_en & w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divided-clock generator with burst, stop and done sequencing.
// Ports: clk/reset, cfg_valid/ready/half/bursts, start, stop, busy, done,
//        out_clk, tick, cycles_left. All outputs registered.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_D,
  parameter int          BURST_W  = BURST_W_D,
  parameter int unsigned DEF_HALF = DEF_HALF_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_bursts,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               out_clk,
  output logic               tick,
  output logic [BURST_W-1:0] cycles_left
);

  state_t               r_state, w_state;
  logic                 r_out_clk, w_out_clk;
  logic                 r_tick, w_tick;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_cfg_ready, w_cfg_ready;
  logic [BURST_W-1:0]   r_left, w_left;
  logic [CNT_W-1:0]     r_half, w_half;
  logic [BURST_W-1:0]   r_burst, w_burst;
  logic                 r_stop_pend, w_stop_pend;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;
  logic                 w_phase_end;
  logic                 w_stopping;
  logic [CNT_W-1:0]     w_cfg_half_c;

  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_cnt_clr),
    .i_en        (w_cnt_en),
    .i_term      (r_half),
    .o_phase_end (w_phase_end)
  );

  assign w_cfg_half_c = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  // A stop arriving on the final LOW cycle still wins over completion.
  assign w_stopping   = r_stop_pend | stop;

  always_comb begin
    w_state     = r_state;
    w_out_clk   = r_out_clk;
    w_tick      = 1'b0;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_cfg_ready = r_cfg_ready;
    w_left      = r_left;
    w_half      = r_half;
    w_burst     = r_burst;
    w_stop_pend = r_stop_pend;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_half  = w_cfg_half_c;
          w_burst = cfg_bursts;
        end
        if (start) begin
          w_state     = S_HIGH;
          w_out_clk   = 1'b1;
          w_tick      = 1'b1;
          w_busy      = 1'b1;
          w_cfg_ready = 1'b0;
          w_left      = cfg_valid ? cfg_bursts : r_burst;
          w_stop_pend = 1'b0;
          w_cnt_clr   = 1'b1;
        end
      end
      S_HIGH: begin
        w_cnt_en = 1'b1;
        if (stop) w_stop_pend = 1'b1;
        if (w_phase_end) begin
          w_state   = S_LOW;
          w_out_clk = 1'b0;
        end
      end
      S_LOW: begin
        w_cnt_en = 1'b1;
        if (stop) w_stop_pend = 1'b1;
        if (w_phase_end) begin
          if (w_stopping) begin
            w_state     = S_IDLE;
            w_busy      = 1'b0;
            w_cfg_ready = 1'b1;
            w_left      = '0;
            w_stop_pend = 1'b0;
          end else if (r_burst != '0 && r_left <= BURST_W'(1)) begin
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_left  = '0;
          end else begin
            w_state   = S_HIGH;
            w_out_clk = 1'b1;
            w_tick    = 1'b1;
            if (r_burst != '0) w_left = r_left - BURST_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state     = S_IDLE;
        w_cfg_ready = 1'b1;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_clk   <= 1'b0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_left      <= '0;
      r_half      <= CNT_W'(DEF_HALF);
      r_burst     <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_out_clk   <= w_out_clk;
      r_tick      <= w_tick;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_cfg_ready <= w_cfg_ready;
      r_left      <= w_left;
      r_half      <= w_half;
      r_burst     <= w_burst;
      r_stop_pend <= w_stop_pend;
    end
  end

  assign out_clk     = r_out_clk;
  assign tick        = r_tick;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_ready   = r_cfg_ready;
  assign cycles_left = r_left;

endmodule
